shift_reg: RTL and testbench

- Serial-in, parallel-out bit accumulator for the Huffman decoder front end.
- Each loaded bit is shifted into the LSB. A bit counter reports how many code bits have been gathered, so downstream match logic can compare {bits, count} against the code table.
- Cleared by reset between codewords.

---
 rtl/huff_pkg.sv | 11 +
 rtl/shift_reg.sv | 65 ++++++
 tb/tb_shift_reg.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/huff_pkg.sv
// Shared Huffman decoder definitions.
// Holds the default code length and the bit-count type. The decoder table and
// the shift_reg front end both use these, so their widths always agree.
package huff_pkg;

  localparam int HUFF_MAX_CODE = 9;   // longest Huffman code, in bits
  localparam int HUFF_CNT_W    = 4;   // width of the gathered-bit counter

  typedef logic [HUFF_CNT_W-1:0] huff_cnt_t;

endpackage

// File: rtl/shift_reg.sv
// shift_reg: serial-in, parallel-out bit accumulator for the Huffman decoder.
// Each loaded bit enters at the LSB. A saturating counter tracks how many code
// bits have been gathered, so match logic can compare {bits, count} against
// the code table. Reset clears all state between codewords.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-low reset; clears bits, count (and ovf)
//   load    shift-enable; in_bit is captured at a clk edge when 1
//   in_bit  next code bit, MSB of the code first
//   bits    accumulated code, right-aligned, newest bit in bits[0]
//   count   number of bits captured, saturating at MAX_CODE
//   full    count == MAX_CODE
//   ovf     (only with SHIFT_REG_OVF_EN) sticky: a load arrived while full
//
// Build option: define SHIFT_REG_OVF_EN to add the ovf output.
module shift_reg
  import huff_pkg::*;
#(
  parameter int MAX_CODE = HUFF_MAX_CODE   // legal 2..15 (count is 4 bits)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                in_bit,
  output logic [MAX_CODE-1:0] bits,
  output huff_cnt_t           count,
`ifdef SHIFT_REG_OVF_EN
  output logic                ovf,
`endif
  output logic                full
);

  localparam huff_cnt_t CNT_MAX = huff_cnt_t'(MAX_CODE);

  generate
    if (MAX_CODE < 2 || MAX_CODE > 15) begin : g_bad_param
      $error("shift_reg: MAX_CODE must be in 2..15");
    end
  endgenerate

  // Shift register and saturating counter share one flop block. Because the
  // register only ever left-shifts from zero, positions at or above count
  // stay 0 without any masking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bits  <= '0;
      count <= '0;
`ifdef SHIFT_REG_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (load) begin
      bits <= {bits[MAX_CODE-2:0], in_bit};
      if (count != CNT_MAX) count <= count + huff_cnt_t'(1);
`ifdef SHIFT_REG_OVF_EN
      // A load into a full register means the code is longer than MAX_CODE.
      if (count == CNT_MAX) ovf <= 1'b1;
`endif
    end
  end

  // Decoded from registered count only; no path from load/in_bit.
  assign full = (count == CNT_MAX);

endmodule

// File: tb/tb_shift_reg.sv
// Self-checking bench for shift_reg (default MAX_CODE = 9).
// Each driven step pushes its predicted outputs onto a scoreboard queue; the
// entry is popped and compared just after the clock edge that produces it.
module tb_shift_reg;

  localparam int MC = 9;

  typedef struct packed {
    logic [MC-1:0] bits;
    logic [3:0]    cnt;
    logic          full;
    logic          ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load = 1'b0;
  logic          in_bit = 1'b0;
  logic [MC-1:0] bits;
  logic [3:0]    count;
  logic          full;
`ifdef SHIFT_REG_OVF_EN
  logic          ovf;
`endif

  int errors = 0;
  int checks = 0;

  exp_t sb[$];

  // reference state
  logic [MC-1:0] m_bits;
  logic [3:0]    m_cnt;
  logic          m_ovf;

  shift_reg #(.MAX_CODE(MC)) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .in_bit (in_bit),
    .bits   (bits),
    .count  (count),
`ifdef SHIFT_REG_OVF_EN
    .ovf    (ovf),
`endif
    .full   (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".bits"},  32'(bits),  32'(e.bits));
    chk({tag, ".count"}, 32'(count), 32'(e.cnt));
    chk({tag, ".full"},  32'(full),  32'(e.full));
`ifdef SHIFT_REG_OVF_EN
    chk({tag, ".ovf"},   32'(ovf),   32'(e.ovf));
`endif
  endtask

  // One clock of stimulus: predict, push, clock, pop and compare.
  task automatic step(input logic ld, input logic b, input string tag);
    exp_t e;
    @(negedge clk);
    load = ld;
    in_bit = b;
    if (ld) begin
      if (m_cnt == 4'(MC)) m_ovf = 1'b1;
      m_bits = {m_bits[MC-2:0], b};
      if (m_cnt != 4'(MC)) m_cnt = m_cnt + 4'd1;
    end
    sb.push_back('{bits: m_bits, cnt: m_cnt, full: (m_cnt == 4'(MC)), ovf: m_ovf});
    @(posedge clk);
    #1;
    load = 1'b0;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s.sb: got empty queue expected an entry", tag);
    end
    if (sb.size() > 0) chk_all(tag, sb.pop_front());
  endtask

  task automatic load_str(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i] == "1", tag);
  endtask

  // Asynchronous reset pulse placed mid-cycle; checked before any clk edge.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    m_bits = '0; m_cnt = '0; m_ovf = 1'b0;
    chk_all({tag, ".async"}, '{bits: '0, cnt: 4'd0, full: 1'b0, ovf: 1'b0});
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic chk_final(input string tag, input logic [MC-1:0] b, input logic [3:0] c, input logic f);
    chk({tag, ".bits"},  32'(bits),  32'(b));
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".full"},  32'(full),  32'(f));
  endtask

  initial begin
    m_bits = '0; m_cnt = '0; m_ovf = 1'b0;

    // held in reset with load active: must stay cleared across edges
    load = 1'b1; in_bit = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_hold", '{bits: '0, cnt: 4'd0, full: 1'b0, ovf: 1'b0});
    load = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // full-length code
    load_str("111110010", "code9");
    chk_final("code9_final", 9'b111110010, 4'd9, 1'b1);

    // single bit then idle cycles
    do_reset("r1");
    load_str("0", "code1");
    chk_final("code1_final", 9'b000000000, 4'd1, 1'b0);
    repeat (3) step(1'b0, 1'b1, "idle");
    chk_final("idle_final", 9'b000000000, 4'd1, 1'b0);

    // partial code aborted by reset between edges
    do_reset("r2");
    load_str("1011001", "code7");
    chk_final("code7_final", 9'b001011001, 4'd7, 1'b0);
    do_reset("r_mid");
    load_str("1", "restart");
    chk_final("restart_final", 9'b000000001, 4'd1, 1'b0);

    // saturation: 10th bit shifts, count holds
    do_reset("r3");
    load_str("111110011", "sat9");
    load_str("0", "sat10");
    chk_final("sat_final", 9'b111100110, 4'd9, 1'b1);
`ifdef SHIFT_REG_OVF_EN
    chk("sat_ovf", 32'(ovf), 32'd1);
    step(1'b0, 1'b0, "ovf_sticky");
    chk("ovf_sticky_final", 32'(ovf), 32'd1);
`endif

    // gaps inside "10111"
    do_reset("r4");
    step(1'b1, 1'b1, "gap");
    step(1'b0, 1'b0, "gap");
    step(1'b1, 1'b0, "gap");
    step(1'b1, 1'b1, "gap");
    step(1'b0, 1'b0, "gap");
    step(1'b1, 1'b1, "gap");
    step(1'b1, 1'b1, "gap");
    chk_final("gap_final", 9'b000010111, 4'd5, 1'b0);

    // code set sweep
    do_reset("r5");
    load_str("100", "c3");
    chk_final("c3_final", 9'b000000100, 4'd3, 1'b0);
    do_reset("r6");
    load_str("11111000", "c8");
    chk_final("c8_final", 9'b011111000, 4'd8, 1'b0);
`ifdef SHIFT_REG_OVF_EN
    chk("c8_ovf_clear", 32'(ovf), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: got no finish expected finish within 100000 time units");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
